// File: rtl/mem_bus_arb_pkg.sv
// Shared types and constants for the memory bus arbiter.
//   arb_state_t    : arbiter FSM states
//   DEF_ADDR_W/_W  : default bus widths
//   CNT_W          : latency counter width (covers MEM_LAT up to 15)
//   MMIO_LED_BASE  : LED MMIO base address used by benches
package mem_bus_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned CNT_W      = 4;

  localparam logic [31:0] MMIO_LED_BASE = 32'hFF20_0000;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StWait,
    StResp
  } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Combinational round-robin priority encoder.
//   req_i : request vector
//   ptr_i : index searched first; search wraps modulo NUM_REQ
//   gnt_o : one-hot winner (all zero when no request)
//   idx_o : binary index of the winner (0 when no request)
module rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IdxW-1:0]    idx_o
);

  int unsigned cand;
  logic        found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_REQ requesters.
// One transaction at a time: grant (IDLE), strobe (ACCESS), MEM_LAT cycles of
// WAIT, then a one-cycle completion (RESP).
//   lock_i        : per-requester lock, present only with MEM_BUS_ARB_LOCK_EN
//   clk_i/reset_ni: clock, synchronous active-low reset
//   req_i/we_i    : per-requester request and write enable
//   adr_i/wdata_i : packed per-requester address and write data
//   gnt_o         : one-hot grant, combinational in IDLE
//   rvalid_o      : one-hot completion; rdata_o valid with it
//   mem_*         : memory port
// Optional feature macro: MEM_BUS_ARB_LOCK_EN (holds the pointer on a locked grant).
module mem_bus_arbiter
  import mem_bus_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned MEM_LAT = 1
) (
`ifdef MEM_BUS_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        lock_i,
`endif
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] adr_i,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      mem_en_o,
  output logic                      mem_we_o,
  output logic [ADDR_W-1:0]         mem_adr_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  input  logic [DATA_W-1:0]         mem_rdata_i
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         state_q;
  logic [IdxW-1:0]    ptr_q;
  logic [IdxW-1:0]    owner_q;
  logic [CNT_W-1:0]   count_q;
  logic               we_q;
  logic [ADDR_W-1:0]  adr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [NUM_REQ-1:0] rvalid_q;
  logic               mem_en_q;
  logic               lock_held_q;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IdxW-1:0]    pick_idx;
  logic [IdxW-1:0]    pick_next;
  logic [IdxW-1:0]    ptr_next;
  logic               lock_grant;

  rr_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_picker (
    .req_i(req_i),
    .ptr_i(ptr_q),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx)
  );

  assign pick_next = (pick_idx == IdxW'(NUM_REQ - 1)) ? '0 : pick_idx + IdxW'(1);
  assign ptr_next  = (ptr_q == IdxW'(NUM_REQ - 1)) ? '0 : ptr_q + IdxW'(1);

`ifdef MEM_BUS_ARB_LOCK_EN
  assign lock_grant = lock_i[pick_idx];
`else
  assign lock_grant = 1'b0;
`endif

  // Grant is combinational so a requester sees it in the same cycle it asks.
  assign gnt_o = (reset_ni && (state_q == StIdle)) ? pick_gnt : '0;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      owner_q     <= '0;
      count_q     <= '0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rvalid_q    <= '0;
      mem_en_q    <= 1'b0;
      lock_held_q <= 1'b0;
    end else begin
      rvalid_q <= '0;
      mem_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|req_i) begin
            owner_q     <= pick_idx;
            we_q        <= we_i[pick_idx];
            adr_q       <= adr_i[pick_idx*ADDR_W +: ADDR_W];
            wdata_q     <= wdata_i[pick_idx*DATA_W +: DATA_W];
            // A locked grant parks the pointer on the winner.
            ptr_q       <= lock_grant ? pick_idx : pick_next;
            lock_held_q <= lock_grant;
            mem_en_q    <= 1'b1;
            state_q     <= StAccess;
          end else if (lock_held_q) begin
            // Lock holder went quiet: release and resume normal rotation.
            ptr_q       <= ptr_next;
            lock_held_q <= 1'b0;
          end
        end
        StAccess: begin
          count_q <= CNT_W'(MEM_LAT - 1);
          state_q <= StWait;
        end
        StWait: begin
          if (count_q == '0) begin
            rdata_q           <= mem_rdata_i;
            rvalid_q[owner_q] <= 1'b1;
            state_q           <= StResp;
          end else begin
            count_q <= count_q - CNT_W'(1);
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_en_q & we_q;
  assign mem_adr_o   = adr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with NUM_REQ=2, MEM_LAT=1 and a
// single-cycle registered-read RAM. Inputs change 1 time unit after a rising
// edge; outputs are sampled 1 time unit later.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [63:0] adr;
  logic [63:0] wdata;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [31:0] rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [1:0]  lock;

  logic [31:0] ram [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_arbiter #(
    .NUM_REQ(2),
    .ADDR_W (32),
    .DATA_W (32),
    .MEM_LAT(1)
  ) dut (
`ifdef MEM_BUS_ARB_LOCK_EN
    .lock_i     (lock),
`endif
    .clk_i      (clk),
    .reset_ni   (reset_n),
    .req_i      (req),
    .we_i       (we),
    .adr_i      (adr),
    .wdata_i    (wdata),
    .gnt_o      (gnt),
    .rvalid_o   (rvalid),
    .rdata_o    (rdata),
    .mem_en_o   (mem_en),
    .mem_we_o   (mem_we),
    .mem_adr_o  (mem_adr),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_adr[7:0]] <= mem_wdata;
      mem_rdata <= ram[mem_adr[7:0]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          ng;
  int          nrv;
  int          gcyc [4];
  logic [1:0]  gvec [4];

  initial begin
    reset_n = 1'b0;
    req     = 2'b11;
    we      = 2'b00;
    adr     = '0;
    wdata   = '0;
    lock    = 2'b00;

    // 1. Reset held with both requesting: all outputs quiet.
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      check("rst_gnt", gnt, 2'b00);
      check("rst_rvalid", rvalid, 2'b00);
      check("rst_mem_en", mem_en, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_rdata", rdata, 32'h0);
    end
    reset_n = 1'b1;
    #1;
    check("rel_gnt", gnt, 2'b01);
    tick();
    req = 2'b00;
    #1;
    check("rel_access_en", mem_en, 1'b1);
    tick();
    tick();
    #1;
    check("rel_rvalid", rvalid, 2'b01);
    tick();

    // 2. Requester 0 writes 0x19 to 0x64.
    req          = 2'b01;
    we           = 2'b01;
    adr[31:0]    = 32'h64;
    wdata[31:0]  = 32'h19;
    #1;
    check("wr_gnt", gnt, 2'b01);
    tick();
    req = 2'b00;
    #1;
    check("wr_gnt_gone", gnt, 2'b00);
    check("wr_mem_en", mem_en, 1'b1);
    check("wr_mem_we", mem_we, 1'b1);
    check("wr_mem_adr", mem_adr, 32'h64);
    check("wr_mem_wdata", mem_wdata, 32'h19);
    tick();
    #1;
    check("wr_wait_en", mem_en, 1'b0);
    check("wr_wait_we", mem_we, 1'b0);
    check("wr_wait_rvalid", rvalid, 2'b00);
    tick();
    #1;
    check("wr_rvalid", rvalid, 2'b01);
    check("wr_ram", ram[8'h64], 32'h19);
    tick();
    #1;
    check("wr_rvalid_gone", rvalid, 2'b00);

    // 3. Requester 1 reads back 0x64.
    req          = 2'b10;
    we           = 2'b00;
    adr[63:32]   = 32'h64;
    #1;
    check("rd_gnt", gnt, 2'b10);
    tick();
    req = 2'b00;
    #1;
    check("rd_mem_en", mem_en, 1'b1);
    check("rd_mem_we", mem_we, 1'b0);
    check("rd_mem_adr", mem_adr, 32'h64);
    tick();
    tick();
    #1;
    check("rd_rvalid", rvalid, 2'b10);
    check("rd_rdata", rdata, 32'h19);
    tick();

    // 4. Both held for 16 cycles: alternate grants every 4 cycles.
    req = 2'b11;
    ng  = 0;
    nrv = 0;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (gnt != 2'b00) begin
        if (ng < 4) begin
          gcyc[ng] = c;
          gvec[ng] = gnt;
        end
        ng++;
      end
      if (rvalid != 2'b00) nrv++;
      tick();
    end
    req = 2'b00;
    check("rr_num_gnt", ng, 4);
    check("rr_num_rvalid", nrv, 4);
    if (ng == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("rr_order", gvec[k], (k % 2 == 0) ? 2'b01 : 2'b10);
        check("rr_spacing", gcyc[k], 4 * k);
      end
    end

    // 5. Reset during WAIT abandons the transaction and resets the pointer.
    req = 2'b01;
    #1;
    check("ab_gnt", gnt, 2'b01);
    tick();
    req = 2'b00;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    req     = 2'b11;
    #1;
    check("ab_no_rvalid", rvalid, 2'b00);
    check("ab_no_mem_en", mem_en, 1'b0);
    check("ab_gnt_after", gnt, 2'b01);
    tick();
    req = 2'b00;
    tick();
    tick();
    #1;
    check("ab_rvalid_after", rvalid, 2'b01);
    tick();

`ifdef MEM_BUS_ARB_LOCK_EN
    // 6. Lock keeps requester 0 winning until lock drops at its third grant.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    req     = 2'b11;
    lock    = 2'b01;
    ng      = 0;
    for (int c = 0; c < 16; c++) begin
      if (c == 8) lock = 2'b00;
      #1;
      if (gnt != 2'b00) begin
        if (ng < 4) begin
          gcyc[ng] = c;
          gvec[ng] = gnt;
        end
        ng++;
      end
      tick();
    end
    req = 2'b00;
    check("lk_num_gnt", ng, 4);
    if (ng == 4) begin
      check("lk_gnt0", gvec[0], 2'b01);
      check("lk_gnt1", gvec[1], 2'b01);
      check("lk_gnt2", gvec[2], 2'b01);
      check("lk_gnt3", gvec[3], 2'b10);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
